// File: rtl/load_wb_align.sv
// ---------------------------------------------------------------------------
// load_wb_align
//
// Load-return and writeback alignment stage. Load control and address are
// registered at the X/WB boundary so that the one-cycle synchronous read
// latency of the DMEM/BIOS BRAMs lines up with the WB stage. In WB the raw
// word is chosen by address region, then aligned and sign/zero-extended by
// funct3. The block also owns the MMIO read mux and the cycle/instruction
// counters.
//
// Optional feature macro: MMIO_COUNTERS_EN
//   defined   -> cycle/instruction counters and the reset-on-write register
//   undefined -> no counter flops, counter reads return 0, writes ignored
//
// Ports:
//   clk, rst         core clock, synchronous active-high reset
//   stall            pipeline stall, WB-side state holds
//   ex_valid         X-stage instruction valid
//   ex_mem_read      X-stage instruction is a load
//   ex_mem_write     X-stage instruction is a store
//   ex_funct3        instr[14:12] of the X-stage instruction
//   ex_addr          effective address from the ALU
//   wb_retire        one instruction retires this cycle
//   dmem_dout        DMEM read data (valid the cycle after the address)
//   bios_dout        BIOS read data (valid the cycle after the address)
//   uart_rx_data     UART received byte
//   uart_rx_valid    UART byte available
//   uart_tx_ready    UART transmitter idle
//   uart_rx_ack      one-cycle pulse when the rx byte is consumed
//   wb_load_valid    wb_load_data belongs to a load in WB
//   wb_load_data     aligned, extended load result
// ---------------------------------------------------------------------------
module load_wb_align #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic [2:0]       ex_funct3,
    input  logic [WIDTH-1:0] ex_addr,
    input  logic             wb_retire,
    input  logic [WIDTH-1:0] dmem_dout,
    input  logic [WIDTH-1:0] bios_dout,
    input  logic [7:0]       uart_rx_data,
    input  logic             uart_rx_valid,
    input  logic             uart_tx_ready,
    output logic             uart_rx_ack,
    output logic             wb_load_valid,
    output logic [WIDTH-1:0] wb_load_data
);

    localparam logic [31:0] ADDR_UART_STAT = 32'h8000_0000;
    localparam logic [31:0] ADDR_UART_RX   = 32'h8000_0004;
    localparam logic [31:0] ADDR_CYCLE     = 32'h8000_0010;
    localparam logic [31:0] ADDR_INSTR     = 32'h8000_0014;

    logic             ld_v;
    logic [2:0]       funct3_q;
    logic [3:0]       region;
    logic [1:0]       offset;
    logic [WIDTH-1:0] io_word;
    logic             rx_load;
    logic             first_wb;
    logic             hold_v;
    logic [WIDTH-1:0] hold_word;

    logic [31:0]      cycle_cnt;
    logic [31:0]      instr_cnt;
    logic [WIDTH-1:0] io_next;
    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] raw_word;
    logic [WIDTH-1:0] ext_word;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

`ifdef MMIO_COUNTERS_EN
    localparam logic [31:0] ADDR_CNT_CLR = 32'h8000_0018;

    logic cnt_clear;

    // A store to the clear address zeroes both counters, winning over any
    // increment (including a retire) in the same cycle.
    assign cnt_clear = ex_valid & ex_mem_write & ~stall & (ex_addr == ADDR_CNT_CLR);

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (wb_retire) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_cnt_inputs;

    assign cycle_cnt         = '0;
    assign instr_cnt         = '0;
    assign unused_cnt_inputs = wb_retire ^ ex_mem_write;
`endif

    // MMIO reads are resolved in X so counter reads return the value present
    // during the load's X cycle; the result is registered into io_word.
    always_comb begin
        io_next = '0;
        case (ex_addr)
            ADDR_UART_STAT: io_next = {30'b0, uart_rx_valid, uart_tx_ready};
            ADDR_UART_RX:   io_next = {24'b0, uart_rx_data};
            ADDR_CYCLE:     io_next = cycle_cnt;
            ADDR_INSTR:     io_next = instr_cnt;
            default:        io_next = '0;
        endcase
    end

    // first_wb marks the first WB cycle of whatever was captured; it drops on
    // any stall so the UART ack cannot repeat while the load sits in WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_v     <= 1'b0;
            funct3_q <= '0;
            region   <= '0;
            offset   <= '0;
            io_word  <= '0;
            rx_load  <= 1'b0;
            first_wb <= 1'b0;
        end else if (!stall) begin
            ld_v     <= ex_valid & ex_mem_read;
            funct3_q <= ex_funct3;
            region   <= ex_addr[31:28];
            offset   <= ex_addr[1:0];
            io_word  <= io_next;
            rx_load  <= (ex_addr == ADDR_UART_RX);
            first_wb <= 1'b1;
        end else begin
            first_wb <= 1'b0;
        end
    end

    // The BRAM outputs are only valid in the first WB cycle, so the raw word
    // is snapshotted on the first stalled cycle and used until stall drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v    <= 1'b0;
            hold_word <= '0;
        end else if (stall) begin
            if (ld_v && !hold_v) begin
                hold_v    <= 1'b1;
                hold_word <= sel_word;
            end
        end else begin
            hold_v <= 1'b0;
        end
    end

    always_comb begin
        sel_word = '0;
        case (region)
            4'b0001, 4'b0011: sel_word = dmem_dout;
            4'b0100:          sel_word = bios_dout;
            4'b1000:          sel_word = io_word;
            default:          sel_word = '0;
        endcase
    end

    assign raw_word = hold_v ? hold_word : sel_word;

    always_comb begin
        byte_sel = raw_word[7:0];
        case (offset)
            2'd0: byte_sel = raw_word[7:0];
            2'd1: byte_sel = raw_word[15:8];
            2'd2: byte_sel = raw_word[23:16];
            2'd3: byte_sel = raw_word[31:24];
            default: byte_sel = raw_word[7:0];
        endcase
    end

    assign half_sel = offset[1] ? raw_word[31:16] : raw_word[15:0];

    always_comb begin
        ext_word = raw_word;
        case (funct3_q)
            3'b000:  ext_word = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ext_word = {{16{half_sel[15]}}, half_sel};
            3'b100:  ext_word = {24'b0, byte_sel};
            3'b101:  ext_word = {16'b0, half_sel};
            default: ext_word = raw_word;
        endcase
    end

    assign wb_load_valid = ld_v;
    assign wb_load_data  = ld_v ? ext_word : '0;
    assign uart_rx_ack   = ld_v & rx_load & first_wb;

endmodule

// File: tb/tb_load_wb_align.sv
// ---------------------------------------------------------------------------
// tb_load_wb_align
//
// Self-checking bench for load_wb_align. A transaction-level model tracks the
// load sitting in WB (its address, funct3 and MMIO snapshot) plus the two
// counters, and predicts valid/data/ack each cycle. Directed scenarios run
// first, followed by a randomized stream of loads, stores, stalls and resets.
// Counter expectations follow MMIO_COUNTERS_EN.
// ---------------------------------------------------------------------------
module tb_load_wb_align;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic        wb_retire;
    logic [31:0] dmem_dout;
    logic [31:0] bios_dout;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_tx_ready;
    logic        uart_rx_ack;
    logic        wb_load_valid;
    logic [31:0] wb_load_data;

    always #5 clk = ~clk;

    load_wb_align #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_funct3     (ex_funct3),
        .ex_addr       (ex_addr),
        .wb_retire     (wb_retire),
        .dmem_dout     (dmem_dout),
        .bios_dout     (bios_dout),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_ack   (uart_rx_ack),
        .wb_load_valid (wb_load_valid),
        .wb_load_data  (wb_load_data)
    );

    int tests = 0;
    int fails = 0;

    // Model of the instruction in WB and of the counters.
    bit          mLoad   = 0;
    bit          mFirst  = 0;
    logic [2:0]  mF3     = '0;
    logic [31:0] mAddr   = '0;
    logic [31:0] mIo     = '0;
    logic [31:0] mFrozen = '0;
    logic [31:0] mCycles = '0;
    logic [31:0] mInstrs = '0;

    logic [31:0] expData;
    bit          expValid;
    bit          expAck;
    logic [31:0] obsData;
    logic        obsValid;
    logic        obsAck;

    logic [31:0] ioAddrs [8] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0010,
                                 32'h8000_0014, 32'h8000_0018, 32'h8000_000C,
                                 32'h8000_0001, 32'h8000_0100};

    function automatic logic [31:0] counterRead(input logic [31:0] value);
`ifdef MMIO_COUNTERS_EN
        return value;
`else
        return (value & 32'h0);
`endif
    endfunction

    function automatic logic [31:0] ioValue(input logic [31:0] addr);
        if (addr == 32'h8000_0000) return {30'b0, uart_rx_valid, uart_tx_ready};
        if (addr == 32'h8000_0004) return {24'b0, uart_rx_data};
        if (addr == 32'h8000_0010) return counterRead(mCycles);
        if (addr == 32'h8000_0014) return counterRead(mInstrs);
        return 32'h0;
    endfunction

    function automatic logic [31:0] regionWord(input logic [31:0] addr);
        int top;
        top = int'(addr >> 28);
        if (top == 1 || top == 3) return dmem_dout;
        if (top == 4) return bios_dout;
        if (top == 8) return mIo;
        return 32'h0;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                            input int off);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'd32768) ? (h + 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic applyStimulus(input bit r, input bit v, input bit rd, input bit wr,
                                 input logic [2:0] f3, input logic [31:0] addr,
                                 input bit st, input bit ret,
                                 input logic [31:0] dm, input logic [31:0] bi);
        rst          = r;
        ex_valid     = v;
        ex_mem_read  = rd;
        ex_mem_write = wr;
        ex_funct3    = f3;
        ex_addr      = addr;
        stall        = st;
        wb_retire    = ret;
        dmem_dout    = dm;
        bios_dout    = bi;
    endtask

    task automatic checkOutput(input string tag);
        expValid = mLoad;
        expAck   = mLoad && mFirst && (mAddr == 32'h8000_0004);
        if (!mLoad) expData = 32'h0;
        else if (mFirst) expData = extract(regionWord(mAddr), mF3, int'(mAddr[1:0]));
        else expData = mFrozen;
        obsData  = wb_load_data;
        obsValid = wb_load_valid;
        obsAck   = uart_rx_ack;
        tests++;
        assert (obsValid === expValid) else begin
            fails++;
            $error("[TB] FAIL %s valid: got %b expected %b", tag, obsValid, expValid);
        end
        tests++;
        assert (obsData === expData) else begin
            fails++;
            $error("[TB] FAIL %s data: got %08h expected %08h", tag, obsData, expData);
        end
        tests++;
        assert (obsAck === expAck) else begin
            fails++;
            $error("[TB] FAIL %s ack: got %b expected %b", tag, obsAck, expAck);
        end
    endtask

    // Hand-computed values from the scenario descriptions, compared against
    // the outputs sampled by the most recent checkOutput.
    task automatic checkKnown(input string tag, input bit v, input logic [31:0] d);
        tests++;
        assert (obsValid === v && obsData === d) else begin
            fails++;
            $error("[TB] FAIL %s: got valid=%b data=%08h expected valid=%b data=%08h",
                   tag, obsValid, obsData, v, d);
        end
    endtask

    task automatic checkAck(input string tag, input bit a);
        tests++;
        assert (obsAck === a) else begin
            fails++;
            $error("[TB] FAIL %s: got ack=%b expected ack=%b", tag, obsAck, a);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            mLoad   = 0;
            mFirst  = 0;
            mCycles = '0;
            mInstrs = '0;
        end else begin
            if (!stall) begin
                mLoad  = ex_valid && ex_mem_read;
                mAddr  = ex_addr;
                mF3    = ex_funct3;
                mIo    = ioValue(ex_addr);
                mFirst = 1;
            end else begin
                if (mLoad && mFirst) mFrozen = expData;
                mFirst = 0;
            end
            if (ex_valid && ex_mem_write && !stall && ex_addr == 32'h8000_0018) begin
                mCycles = '0;
                mInstrs = '0;
            end else begin
                mCycles = mCycles + 32'd1;
                if (wb_retire) mInstrs = mInstrs + 32'd1;
            end
        end
        #1;
    endtask

    task automatic runCycle(input string tag, input bit r, input bit v, input bit rd,
                            input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                            input bit st, input bit ret,
                            input logic [31:0] dm, input logic [31:0] bi);
        applyStimulus(r, v, rd, wr, f3, addr, st, ret, dm, bi);
        @(negedge clk);
        checkOutput(tag);
        advance();
    endtask

    task automatic idle(input string tag, input bit st, input bit ret,
                        input logic [31:0] dm, input logic [31:0] bi);
        runCycle(tag, 0, 0, 0, 0, 3'd0, 32'h0, st, ret, dm, bi);
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] cntExpect;
        bit          isRead;
        bit          isWrite;

        uart_rx_data  = 8'hA5;
        uart_rx_valid = 1'b1;
        uart_tx_ready = 1'b0;
        applyStimulus(1, 0, 0, 0, 3'd0, 32'h0, 0, 0, 32'h0, 32'h0);
        @(posedge clk);
        #1;

        runCycle("reset0", 1, 0, 0, 0, 3'd0, 32'h0, 0, 0, 32'h0, 32'h0);
        checkKnown("reset_outputs", 0, 32'h0);
        checkAck("reset_ack", 0);

        // LB with sign extension from the top byte.
        runCycle("lb_x", 0, 1, 1, 0, 3'b000, 32'h1000_0003, 0, 0, 32'h0, 32'h0);
        idle("lb_wb", 0, 0, 32'h8012_3456, 32'h0);
        checkKnown("lb_sign", 1, 32'hFFFF_FF80);

        // Back-to-back LHU then LH from BIOS.
        runCycle("lhu_x", 0, 1, 1, 0, 3'b101, 32'h4000_0002, 0, 0, 32'h0, 32'h0);
        runCycle("lh_x", 0, 1, 1, 0, 3'b001, 32'h4000_0002, 0, 0, 32'h0, 32'hBEEF_1234);
        checkKnown("lhu_zero", 1, 32'h0000_BEEF);
        idle("lh_wb", 0, 0, 32'h0, 32'hBEEF_1234);
        checkKnown("lh_sign", 1, 32'hFFFF_BEEF);

        // LW held across a three-cycle stall while the BRAM output changes.
        runCycle("lw_x", 0, 1, 1, 0, 3'b010, 32'h1000_0000, 0, 0, 32'h0, 32'h0);
        idle("lw_wb0", 1, 0, 32'hCAFE_F00D, 32'h0);
        checkKnown("lw_stall0", 1, 32'hCAFE_F00D);
        idle("lw_wb1", 1, 0, 32'h0, 32'h0);
        checkKnown("lw_stall1", 1, 32'hCAFE_F00D);
        idle("lw_wb2", 1, 0, 32'h0, 32'h0);
        checkKnown("lw_stall2", 1, 32'hCAFE_F00D);
        idle("lw_wb3", 0, 0, 32'h0, 32'h0);
        checkKnown("lw_release", 1, 32'hCAFE_F00D);

        // Counter clear (with a simultaneous retire), then read both counters.
        runCycle("cnt_clr", 0, 1, 0, 1, 3'b010, 32'h8000_0018, 0, 1, 32'h0, 32'h0);
        for (int i = 1; i <= 9; i++) idle("cnt_gap", 0, (i <= 4), 32'h0, 32'h0);
        runCycle("cyc_x", 0, 1, 1, 0, 3'b010, 32'h8000_0010, 0, 0, 32'h0, 32'h0);
        runCycle("ins_x", 0, 1, 1, 0, 3'b010, 32'h8000_0014, 0, 0, 32'h0, 32'h0);
`ifdef MMIO_COUNTERS_EN
        cntExpect = 32'd9;
`else
        cntExpect = 32'd0;
`endif
        checkKnown("cycle_read", 1, cntExpect);
        idle("ins_wb", 0, 0, 32'h0, 32'h0);
`ifdef MMIO_COUNTERS_EN
        cntExpect = 32'd4;
`else
        cntExpect = 32'd0;
`endif
        checkKnown("instr_read", 1, cntExpect);

        // UART rx read with a two-cycle stall: ack once only.
        runCycle("rx_x", 0, 1, 1, 0, 3'b100, 32'h8000_0004, 0, 0, 32'h0, 32'h0);
        idle("rx_wb0", 1, 0, 32'h0, 32'h0);
        checkKnown("rx_data", 1, 32'h0000_00A5);
        checkAck("rx_ack_first", 1);
        idle("rx_wb1", 1, 0, 32'h0, 32'h0);
        checkAck("rx_ack_stall", 0);
        idle("rx_wb2", 0, 0, 32'h0, 32'h0);
        checkAck("rx_ack_release", 0);
        checkKnown("rx_data_held", 1, 32'h0000_00A5);
        runCycle("rx2_x", 0, 1, 1, 0, 3'b100, 32'h8000_0004, 0, 0, 32'h0, 32'h0);
        idle("rx2_wb", 0, 0, 32'h0, 32'h0);
        checkAck("rx2_ack", 1);
        idle("rx2_after", 0, 0, 32'h0, 32'h0);
        checkAck("rx2_ack_gone", 0);

        // Reset arriving in a load's WB cycle.
        runCycle("rst_x", 0, 1, 1, 0, 3'b010, 32'h1000_0000, 0, 0, 32'h0, 32'h0);
        runCycle("rst_wb", 1, 0, 0, 0, 3'd0, 32'h0, 0, 1, 32'h1234_5678, 32'h0);
        runCycle("rst_after", 0, 1, 1, 0, 3'b010, 32'h8000_0010, 0, 0, 32'h1234_5678, 32'h0);
        checkKnown("rst_discard", 0, 32'h0);
        runCycle("rst_ins_x", 0, 1, 1, 0, 3'b010, 32'h8000_0014, 0, 0, 32'h0, 32'h0);
        checkKnown("rst_cycle_read", 1, 32'h0);
        idle("rst_ins_wb", 0, 0, 32'h0, 32'h0);
        checkKnown("rst_instr_read", 1, 32'h0);

        // Randomized traffic checked against the model.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0: addr = {($urandom_range(0, 1) != 0) ? 4'h1 : 4'h3, 28'($urandom)};
                1: addr = {4'h4, 28'($urandom)};
                2: addr = ioAddrs[$urandom_range(0, 7)];
                default: addr = $urandom;
            endcase
            isRead  = ($urandom_range(0, 2) != 0);
            isWrite = !isRead && ($urandom_range(0, 1) != 0);
            if (isWrite && $urandom_range(0, 3) == 0) addr = 32'h8000_0018;
            uart_rx_data  = 8'($urandom);
            uart_rx_valid = 1'($urandom);
            uart_tx_ready = 1'($urandom);
            runCycle("rand", ($urandom_range(0, 49) == 0), 1'($urandom), isRead, isWrite,
                     3'($urandom), addr, ($urandom_range(0, 3) == 0), 1'($urandom),
                     $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
